// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencer state encoding, register constants
//   and the RV32I major opcodes used by the control unit.
// No logic; types and constants only.
package pipe_pkg;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // Architectural zero register
  localparam logic [4:0] REG_X0 = 5'd0;

  // RV32I major opcodes, shared with the control unit
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/luh_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the rd of a
//   load currently in EX. Purely combinational, zero latency, no backpressure.
// Ports: ID source fields/use flags, EX rd and load flag in; luh_o out.
module luh_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mr_i,
  output logic       luh_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

  // A load to x0 produces nothing to forward, so it never hazards.
  assign luh_o = ex_mr_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, redirect flushes, memory-wait freeze
//   with timeout watchdog, and a stall-cycle counter. Controls are
//   combinational in-cycle; state/counters update at the next posedge.
// Ports: clk/rst, hazard and memory handshake inputs; stage enables, flushes,
//   stall, sticky bus_err and stall_cnt outputs.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MR,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               luh;
  logic               mem_stall;

  luh_detect u_luh (
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .ex_rd_i      (ex_rd),
    .ex_mr_i      (ex_MR),
    .luh_o        (luh)
  );

  // Only an access that is not completing this very cycle freezes the pipe.
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    bus_err_d  = bus_err_q;
    stall      = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          // Whole pipe frozen; a pending redirect stays parked in EX.
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else if (ex_redirect) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (luh) begin
          // Hold IF/ID, let the load advance; the control unit bubbles ID.
          stall    = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      stall      = 1'b1;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end

    stall_cnt_d = pc_en ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_MR, ex_redirect, mem_req, mem_ready;
  logic             stall, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, bus_err;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_init    = 0;   // model registers known (after first reset edge)
  bit          m_frozen  = 0;   // inside a memory wait
  int          m_waited  = 0;   // frozen cycles spent on the current access
  bit          m_err     = 0;
  longint      m_cnt     = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_MR(ex_MR), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall(stall), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit mr, input bit redir,
                        input bit req, input bit rdy);
    id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = 5'(rd); ex_MR = mr; ex_redirect = redir; mem_req = req; mem_ready = rdy;
  endtask

  // One cycle: check mid-cycle against the model, then advance model at the edge.
  task automatic step();
    bit hz;
    logic [6:0] exp_ctl;   // {stall,pc_en,ifid_en,idex_en,exmem_en,ifid_flush,idex_flush}
    #3;
    hz = ex_MR && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst)                        exp_ctl = 7'b1000011;
    else if (m_err)                 exp_ctl = 7'b1000000;
    else if (m_frozen)              exp_ctl = 7'b0000000;
    else if (mem_req && !mem_ready) exp_ctl = 7'b0000000;
    else if (ex_redirect)           exp_ctl = 7'b0111111;
    else if (hz)                    exp_ctl = 7'b1001100;
    else                            exp_ctl = 7'b0111100;
    chk("ctl", {57'd0, stall, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush},
        {57'd0, exp_ctl});
    if (m_init) begin
      chk("bus_err",   {63'd0, bus_err}, {63'd0, m_err});
      chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt[31:0]});
    end
    @(posedge clk);
    if (rst) begin
      m_init = 1; m_frozen = 0; m_waited = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (exp_ctl[5] == 1'b0) m_cnt = (m_cnt + 1) % (64'd1 << CNT_W);
      if (m_err) begin
        // held until reset
      end else if (m_frozen) begin
        if (mem_ready) begin
          m_frozen = 0; m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited == TMO) begin m_err = 1; m_frozen = 0; end
        end
      end else if (mem_req && !mem_ready) begin
        m_frozen = 1; m_waited = 1;
      end
    end
    #1;
  endtask

  initial begin
    longint c0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(); step();
    rst = 1'b0;
    chk("rst_cnt", {32'd0, stall_cnt}, 64'd0);
    chk("rst_err", {63'd0, bus_err}, 64'd0);

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID
    set_in(5, 7, 1, 1, 5, 1, 0, 0, 1); step();
    chk("lu_cnt", {32'd0, stall_cnt}, 64'd1);
    set_in(5, 7, 1, 1, 0, 0, 0, 0, 1); step();
    chk("lu_after_cnt", {32'd0, stall_cnt}, 64'd1);

    // x0 load and unused source
    set_in(0, 3, 1, 1, 0, 1, 0, 0, 1); step();
    set_in(1, 5, 1, 0, 5, 1, 0, 0, 1); step();

    // Redirect together with a load-use hazard
    set_in(5, 7, 1, 1, 5, 1, 1, 0, 1); step();

    // Memory wait: 3 not-ready cycles then ready
    c0 = longint'(stall_cnt);
    set_in(1, 2, 1, 1, 9, 0, 0, 1, 0); step(); step(); step();
    mem_ready = 1'b1; step();
    chk("mw_cnt", {32'd0, stall_cnt}, 64'(c0 + 4));
    mem_req = 1'b0; step();
    chk("mw_err", {63'd0, bus_err}, 64'd0);

    // Timeout and reset recovery
    mem_req = 1'b1; mem_ready = 1'b0;
    step(); step(); step(); step();
    chk("tmo_err", {63'd0, bus_err}, 64'd1);
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    chk("tmo_clr", {63'd0, bus_err}, 64'd0);
    mem_req = 1'b0; step();

    // Redirect held across a 2-cycle wait, flush on first RUN cycle
    set_in(1, 2, 0, 0, 3, 0, 1, 1, 0); step(); step();
    mem_ready = 1'b1; step();
    mem_req = 1'b0; step();
    ex_redirect = 1'b0; step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(99) < 2);
      id_rs1      = 5'($urandom_range(3));
      id_rs2      = 5'($urandom_range(3));
      id_use_rs1  = 1'($urandom_range(1));
      id_use_rs2  = 1'($urandom_range(1));
      ex_rd       = 5'($urandom_range(3));
      ex_MR       = ($urandom_range(99) < 40);
      ex_redirect = ($urandom_range(99) < 15);
      mem_req     = ($urandom_range(99) < 30);
      mem_ready   = ($urandom_range(99) < 60);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Detects load-use hazards and generates the `stall` input consumed by the control unit, which zeroes ID-stage control outputs to form a bubble.
- Generates IF/ID and ID/EX flushes on taken branch/jump redirects.
- Freezes the whole pipeline while data memory is not ready. Includes a memory timeout watchdog and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, cycles in MEM_WAIT before fatal bus error (≥2)
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX
ex_MR  in  1  EX instruction is a load
ex_redirect  in  1  branch taken / jmp / jalr resolved in EX
mem_req  in  1  MEM-stage instruction has MR or MW
mem_ready  in  1  data memory completes access this cycle
stall  out  1  to control unit; forces bubble controls
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID register enable
idex_en  out  1  ID/EX register enable
exmem_en  out  1  EX/MEM and MEM/WB enable
ifid_flush  out  1  clear IF/ID to NOP
idex_flush  out  1  clear ID/EX to NOP
bus_err  out  1  sticky memory timeout error
stall_cnt  out  CNT_W  total cycles with pc_en=0 since reset

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.
- Ports are named `clk` and `rst`.

State register: RUN, MEM_WAIT, ERR (2 bits). The wait counter `wcnt` is $clog2(MEM_TIMEOUT)+1 bits wide.

Reset (`rst`=1 sampled at posedge):
- state=RUN, wcnt=0, bus_err=0, stall_cnt=0.
- While `rst` is high, outputs are forced: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_flush=1, stall=1.
- Reset mid-MEM_WAIT or in ERR returns to RUN on the next edge.

Load-use hazard (combinational):
- luh = ex_MR & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- rd=x0 never creates a hazard.

RUN, evaluated in priority order:
1. mem_req & !mem_ready:
   - All enables are 0 and stall=0 this cycle. No flushes, even if ex_redirect=1; the redirect is held because EX is frozen.
   - Next state is MEM_WAIT, wcnt←1.
2. Otherwise, if ex_redirect:
   - ifid_flush=1, idex_flush=1, all enables 1, stall=0.
   - Redirect overrides luh, because the ID instruction is discarded anyway.
3. Otherwise, if luh:
   - pc_en=0, ifid_en=0, idex_en=1, exmem_en=1, stall=1.
   - This inserts exactly one bubble. Next cycle the load is in MEM, so luh clears naturally.
4. Otherwise: all enables 1, no flush, stall=0.

MEM_WAIT:
- All enables are 0, flushes 0, stall=0.
- If mem_ready=1: return to RUN, wcnt←0. The completing cycle still has enables 0. RUN rules apply from the next cycle, which re-evaluates redirect/luh with frozen EX/ID contents.
- Otherwise, wcnt increments. When wcnt==MEM_TIMEOUT-1 and mem_ready=0: go to ERR and set bus_err←1.

ERR:
- All enables are 0, stall=1, bus_err=1.
- Held until reset; no exit otherwise.

stall_cnt:
- Increments (wrapping modulo 2^CNT_W) on every non-reset cycle where pc_en=0.

Latency:
- Control outputs are combinational from state + inputs, within the same cycle.
- State, wcnt, bus_err and stall_cnt update at the next posedge.

Simultaneous events:
- mem wait > redirect > load-use.
- mem_ready=1 arriving in the same cycle as the entry condition means no entry to MEM_WAIT. An entry condition requires !mem_ready.

Decomposition:
- Shared package `pipe_pkg`:
  - state encoding localparams RUN=0, MEM_WAIT=1, ERR=2
  - REG_X0=5'd0
  - the opcode constants already used by the control unit, for future reuse
- One sub-module: `luh_detect`, purely combinational, computing `luh` from the register fields. The FSM, counters and output muxing stay in `hazard_ctrl`.

Test Plan:
1. Load-use: EX `lw x5`, ID `add x6,x5,x7` → one cycle with stall=1, pc_en=0, ifid_en=0; next cycle all enables 1; stall_cnt=1.
2. x0 and unused source: EX `lw x0`, ID reads x0 → no stall. EX `lw x5`, ID with id_use_rs2=0 and rs2=5 → no stall.
3. Redirect over hazard: ex_redirect=1 and luh=1 together → ifid_flush=idex_flush=1, stall=0, pc_en=1.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → enables 0 for 4 cycles, stall_cnt +4, return to RUN, bus_err=0.
5. Timeout: MEM_TIMEOUT=4, mem_ready held 0 → bus_err=1 after 4 wait cycles; state ERR; stall=1 thereafter; rst=1 for one cycle clears bus_err and returns to RUN.
6. Redirect during mem wait: ex_redirect=1 throughout a 2-cycle wait → no flush during the wait; flush asserted on the first RUN cycle after mem_ready.
